// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin subtractor: operands captured in parallel, one bit per
// clock through a single full-subtractor cell with a borrow flop between bits.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             brw_d;
    logic             bit_d;
    logic             busy_q;
    logic             done_q;
    logic             bout_q;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs; result bit enters at the MSB end.
    always_comb begin
        bit_d = a_q[0] ^ b_q[0] ^ brw_q;
        brw_d = (~a_q[0] & b_q[0]) | (b_q[0] & brw_q) | (~a_q[0] & brw_q);
        res_d = (res_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
    end

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    brw_q <= brw_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Results are published only here so partial sums never show.
                    if (last_bit) begin
                        diff_q  <= res_d;
                        bout_q  <= brw_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 scenarios plus an exhaustive WIDTH=1 instance.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       bin1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       bout1;

    int         n_pass;
    int         n_total;
    logic [8:0] sb8[$];
    logic [1:0] sb1[$];
    logic [8:0] expv;
    logic [1:0] exp1;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: 9-bit difference, bit 8 is the borrow-out.
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - {8'b0, c};
    endfunction

    // Called at a negedge with the 8-bit DUT idle; returns at the negedge after E0.
    task automatic launch8(input logic [7:0] x, input logic [7:0] y, input logic c);
        a     = x;
        b     = y;
        bin   = c;
        start = 1'b1;
        sb8.push_back(model8(x, y, c));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done8(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (diff !== 8'h00) $display("FAIL reset_diff: got %h want 00", diff); else n_pass++;
        n_total++; if (bout !== 1'b0) $display("FAIL reset_bout: got %b want 0", bout); else n_pass++;
        n_total++; if (busy1 !== 1'b0 || done1 !== 1'b0) $display("FAIL reset_w1: got busy=%b done=%b want 0/0", busy1, done1); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc;
        int bc;
        launch8(8'd5, 8'd3, 1'b0);
        wait_done8(cyc, bc);
        expv = sb8.pop_front();
        n_total++; if (cyc !== 8) $display("FAIL basic_latency: got %0d want 8", cyc); else n_pass++;
        n_total++; if (bc !== 8) $display("FAIL basic_busy_cycles: got %0d want 8", bc); else n_pass++;
        n_total++; if (diff !== expv[7:0]) $display("FAIL basic_diff: got %h want %h", diff, expv[7:0]); else n_pass++;
        n_total++; if (bout !== expv[8]) $display("FAIL basic_bout: got %b want %b", bout, expv[8]); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else n_pass++;
        n_total++; if (diff !== 8'h02) $display("FAIL basic_diff_hold: got %h want 02", diff); else n_pass++;
    endtask

    task automatic test_arith;
        logic [7:0] xs[6] = '{8'd3, 8'd0, 8'hFF, 8'h80, 8'h00, 8'h7F};
        logic [7:0] ys[6] = '{8'd5, 8'd0, 8'hFF, 8'h01, 8'hFF, 8'h7F};
        logic       cs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int cyc;
        int bc;
        for (int i = 0; i < 6; i++) begin
            launch8(xs[i], ys[i], cs[i]);
            wait_done8(cyc, bc);
            expv = sb8.pop_front();
            n_total++; if (cyc !== 8) $display("FAIL arith_latency[%0d]: got %0d want 8", i, cyc); else n_pass++;
            n_total++; if (diff !== expv[7:0]) $display("FAIL arith_diff[%0d]: got %h want %h", i, diff, expv[7:0]); else n_pass++;
            n_total++; if (bout !== expv[8]) $display("FAIL arith_bout[%0d]: got %b want %b", i, bout, expv[8]); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start;
        int cyc;
        launch8(8'd9, 8'd4, 1'b0);
        repeat (2) @(negedge clk);
        cyc   = 2;
        start = 1'b1;
        a     = 8'd1;
        b     = 8'd2;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            a   = 8'($urandom);
            b   = 8'($urandom);
            bin = 1'($urandom);
        end
        start = 1'b0;
        expv = sb8.pop_front();
        n_total++; if (cyc !== 8) $display("FAIL ign_latency: got %0d want 8", cyc); else n_pass++;
        n_total++; if (diff !== expv[7:0]) $display("FAIL ign_diff: got %h want %h", diff, expv[7:0]); else n_pass++;
        n_total++; if (bout !== expv[8]) $display("FAIL ign_bout: got %b want %b", bout, expv[8]); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL ign_no_second_op: got busy=%b want 0", busy); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int dq[$];
        int lowcnt;
        int cyc;
        int bc;
        lowcnt = 0;
        a = 8'd10; b = 8'd1; bin = 1'b0; start = 1'b1;
        sb8.push_back(model8(8'd10, 8'd1, 1'b0));
        @(negedge clk);
        for (int c = 0; c < 31; c++) begin
            if (done === 1'b1) begin
                dq.push_back(c);
                expv = sb8.pop_front();
                n_total++; if (diff !== expv[7:0]) $display("FAIL b2b_diff@%0d: got %h want %h", c, diff, expv[7:0]); else n_pass++;
                n_total++; if (bout !== expv[8]) $display("FAIL b2b_bout@%0d: got %b want %b", c, bout, expv[8]); else n_pass++;
                sb8.push_back(model8(8'd10, 8'd1, 1'b0));
            end
            if (c < 28 && busy !== 1'b1) lowcnt++;
            @(negedge clk);
        end
        start = 1'b0;
        n_total++; if (dq.size() !== 3) $display("FAIL b2b_pulse_count: got %0d want 3", dq.size()); else n_pass++;
        if (dq.size() >= 3) begin
            n_total++; if (dq[1] - dq[0] !== 10) $display("FAIL b2b_spacing1: got %0d want 10", dq[1] - dq[0]); else n_pass++;
            n_total++; if (dq[2] - dq[1] !== 10) $display("FAIL b2b_spacing2: got %0d want 10", dq[2] - dq[1]); else n_pass++;
        end
        n_total++; if (lowcnt !== 4) $display("FAIL b2b_busy_low: got %0d want 4", lowcnt); else n_pass++;
        wait_done8(cyc, bc);
        expv = sb8.pop_front();
        n_total++; if (cyc > 8 || diff !== expv[7:0]) $display("FAIL b2b_last: got diff=%h cyc=%0d want %h within 8", diff, cyc, expv[7:0]); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int cyc;
        int bc;
        int dcnt;
        launch8(8'd7, 8'd2, 1'b0);
        wait_done8(cyc, bc);
        expv = sb8.pop_front();
        n_total++; if (diff !== expv[7:0]) $display("FAIL abort_pre_diff: got %h want %h", diff, expv[7:0]); else n_pass++;
        @(negedge clk);
        launch8(8'd1, 8'd1, 1'b0);
        repeat (3) @(negedge clk);
        n_total++; if (diff !== 8'h05 || busy !== 1'b1) $display("FAIL abort_hold_in_run: got diff=%h busy=%b want 05/1", diff, busy); else n_pass++;
        rst = 1'b1;
        #1;
        void'(sb8.pop_back());
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (diff !== 8'h00) $display("FAIL abort_diff: got %h want 00", diff); else n_pass++;
        n_total++; if (bout !== 1'b0 || done !== 1'b0) $display("FAIL abort_bout_done: got %b/%b want 0/0", bout, done); else n_pass++;
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        n_total++; if (dcnt !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", dcnt); else n_pass++;
        launch8(8'd1, 8'd1, 1'b0);
        wait_done8(cyc, bc);
        expv = sb8.pop_front();
        n_total++; if (cyc !== 8) $display("FAIL abort_post_latency: got %0d want 8", cyc); else n_pass++;
        n_total++; if (diff !== expv[7:0] || bout !== expv[8]) $display("FAIL abort_post_result: got %h/%b want %h/%b", diff, bout, expv[7:0], expv[8]); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_width1;
        for (int i = 0; i < 8; i++) begin
            a1     = 1'(i >> 2);
            b1     = 1'(i >> 1);
            bin1   = 1'(i);
            start1 = 1'b1;
            sb1.push_back({1'b0, a1} - {1'b0, b1} - {1'b0, bin1});
            @(negedge clk);
            start1 = 1'b0;
            n_total++; if (busy1 !== 1'b1 || done1 !== 1'b0) $display("FAIL w1_run[%0d]: got busy=%b done=%b want 1/0", i, busy1, done1); else n_pass++;
            @(negedge clk);
            exp1 = sb1.pop_front();
            n_total++; if (done1 !== 1'b1) $display("FAIL w1_done[%0d]: got %b want 1", i, done1); else n_pass++;
            n_total++; if (diff1 !== exp1[0]) $display("FAIL w1_diff[%0d]: got %b want %b", i, diff1, exp1[0]); else n_pass++;
            n_total++; if (bout1 !== exp1[1]) $display("FAIL w1_bout[%0d]: got %b want %b", i, bout1, exp1[1]); else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_arith();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_width1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b - bin.
- Operands are captured in parallel, then pushed LSB-first through a single full-subtractor cell, one bit per clock.
- A borrow flip-flop carries the borrow between bits.
- Sits as the sequential datapath stage that drives the team's full-subtractor cell; trades area for latency on Basys3 designs where a WIDTH-wide ripple subtractor is not wanted.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32).
- CW, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a subtraction; sampled on clk rising edge.
- a  input  WIDTH  minuend; captured only when start is accepted.
- b  input  WIDTH  subtrahend; captured only when start is accepted.
- bin  input  1  initial borrow-in; captured only when start is accepted.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse; diff/bout are valid and newly updated.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- One clock domain (clk).
- rst is asynchronous and active-high:
  - On assertion: state=IDLE, busy=0, done=0, diff=0, bout=0; internal shift registers, borrow flop and counter cleared.
  - An operation in progress is abandoned; no done pulse is issued for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 accepts the operation: a_sh<=a, b_sh<=b, brw<=bin, cnt<=0, res_sh<=0, state<=RUN.
  - busy=1 from after E0.
  - start=0 keeps the FSM in IDLE.
- RUN, at each edge:
  - d = a_sh[0]^b_sh[0]^brw.
  - brw <= (~a_sh[0]&b_sh[0]) | (b_sh[0]&brw) | (~a_sh[0]&brw).
  - res_sh <= {d, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; cnt <= cnt+1.
  - Bit i is processed at edge E0+1+i.
- RUN exit:
  - On the edge that processes bit WIDTH-1 (edge E0+WIDTH): diff <= final shifted result, bout <= final borrow, done <= 1, busy <= 0, state <= DONE.
- DONE:
  - Lasts exactly one cycle; at the next edge done <= 0 and state <= IDLE.
- Latency and throughput:
  - done is high in the cycle following edge E0+WIDTH.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start is ignored in RUN and DONE; no queuing. A start held high continuously is re-accepted in the first IDLE cycle.
- a, b and bin changing after acceptance have no effect on the result.
- diff and bout change only on the RUN->DONE transition (or reset). They hold their value through IDLE and through the whole next RUN, so partial results are never visible.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - bout=1 exactly when a < b+bin as integers.
  - Signed interpretation is left to the consumer.
- WIDTH=1: a single RUN cycle; done is high in the cycle after E0+1.

Test Plan:
- WIDTH=8, a=5, b=3, bin=0, start pulsed at E0 -> busy=1 for 8 cycles; done pulse after E0+8; diff=8'h02, bout=0.
- a=3, b=5, bin=0 -> diff=8'hFE, bout=1. Also a=0, b=0, bin=1 -> diff=8'hFF, bout=1. Also a=8'hFF, b=8'hFF, bin=0 -> diff=8'h00, bout=0.
- Start a=9, b=4; at E0+3 drive start=1 with a=1, b=2 and change a/b every cycle -> result diff=8'h05, bout=0; no second operation begins until IDLE.
- Hold start=1 continuously with a=10, b=1 -> done pulses every 10 cycles (WIDTH+2); diff=8'h09 each time; busy low for exactly 2 cycles (DONE, IDLE) between runs.
- Complete a=7, b=2 (diff=5), then start a=1, b=1; assert rst at E0+4 -> diff=0, bout=0, busy=0 immediately; no done pulse. After release, a=1, b=1 completes with diff=0, bout=0.
- WIDTH=1 instance: exhaustive over a, b, bin (8 cases) -> diff and bout match the full-subtractor truth table; done high in the cycle after E0+1.
